tim_base_core: RTL and testbench

//  Timer engine driven by the TIME_BASE CSR block; it sequences the prescaler and the main counter.
//  It takes the CSR outputs: EN, AR, DIR, UD, DIV, PER and LOAD.
//  It returns CNT and the sticky status flags OF, OP, ERR and LD to the CSR inputs.
//  It also drives a one-cycle event pulse for the interrupt logic.

---
 rtl/tim_base_core.sv | 184 ++++++++++++++++++
 tb/tb_tim_base_core.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tim_base_core.sv
// tim_base_core: timer engine behind the TIME_BASE CSR block.
// Runs a prescaler and an up/down main counter with auto-reload or one-shot
// behaviour. It also returns sticky status flags and 1-cycle tick/event pulses.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   en_in, ar_in, dir_in     enable, auto-reload, direction (1 = down)
//   ud_in                    a rising edge requests a load of load_in
//   div_in                   prescaler divide value (step every div_in+1 clocks)
//   per_in, load_in          terminal count and load value
//   cnt_out                  current count
//   of_out, op_out           sticky wrap / terminal-reached flags
//   err_out, ld_out          sticky load-rejected-or-bad-enable / load-accepted flags
//   tick_out, evt_out        1-cycle pulses on counter step / terminal event
module tim_base_core #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned PSC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_in,
  input  logic             ar_in,
  input  logic             dir_in,
  input  logic             ud_in,
  input  logic [PSC_W-1:0] div_in,
  input  logic [CNT_W-1:0] per_in,
  input  logic [CNT_W-1:0] load_in,
  output logic [CNT_W-1:0] cnt_out,
  output logic             of_out,
  output logic             op_out,
  output logic             err_out,
  output logic             ld_out,
  output logic             tick_out,
  output logic             evt_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic             of_q, of_d, op_q, op_d, err_q, err_d, ld_q, ld_d;
  logic             tick_q, tick_d, evt_q, evt_d;
  logic             ud_q, ud_d;
  logic             load_req_c, load_ok_c, psc_tick_c;

  // Next-state, counter, prescaler and flag logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    psc_d      = psc_q;
    of_d       = of_q;
    op_d       = op_q;
    err_d      = err_q;
    ld_d       = ld_q;
    tick_d     = 1'b0;
    evt_d      = 1'b0;
    ud_d       = ud_in;
    psc_tick_c = 1'b0;
    load_req_c = ud_in & ~ud_q;
    load_ok_c  = load_req_c && (load_in <= per_in);

    case (state_q)
      ST_IDLE: begin
        if (en_in) begin
          if (per_in != '0) begin
            state_d = ST_RUN;
            psc_d   = '0;
            of_d    = 1'b0;
            op_d    = 1'b0;
            err_d   = 1'b0;
            ld_d    = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (!en_in) begin
          state_d = ST_IDLE;
          psc_d   = '0;
        end else if (psc_q == div_in) begin
          psc_tick_c = 1'b1;
          psc_d      = '0;
        end else begin
          // Plain increment: if div_in was lowered below psc, this wraps round.
          psc_d = psc_q + PSC_W'(1);
        end
      end
      ST_DONE: begin
        if (!en_in) begin
          state_d = ST_IDLE;
          psc_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Counter step; an accepted load in the same cycle suppresses it.
    if (psc_tick_c && !load_ok_c) begin
      tick_d = 1'b1;
      if (!dir_in) begin
        if (cnt_q >= per_in) begin
          evt_d = 1'b1;
          op_d  = 1'b1;
          if (ar_in) begin
            cnt_d = '0;
            of_d  = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          evt_d = 1'b1;
          op_d  = 1'b1;
          if (ar_in) begin
            cnt_d = per_in;
            of_d  = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end

    // Load is applied last so its flag sets win over the enable-time clear.
    if (load_req_c) begin
      if (load_ok_c) begin
        cnt_d = load_in;
        psc_d = '0;
        ld_d  = 1'b1;
        if (state_q == ST_DONE && en_in) begin
          state_d = ST_RUN;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      psc_q   <= '0;
      of_q    <= 1'b0;
      op_q    <= 1'b0;
      err_q   <= 1'b0;
      ld_q    <= 1'b0;
      tick_q  <= 1'b0;
      evt_q   <= 1'b0;
      ud_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      psc_q   <= psc_d;
      of_q    <= of_d;
      op_q    <= op_d;
      err_q   <= err_d;
      ld_q    <= ld_d;
      tick_q  <= tick_d;
      evt_q   <= evt_d;
      ud_q    <= ud_d;
    end
  end

  assign cnt_out  = cnt_q;
  assign of_out   = of_q;
  assign op_out   = op_q;
  assign err_out  = err_q;
  assign ld_out   = ld_q;
  assign tick_out = tick_q;
  assign evt_out  = evt_q;

endmodule

// File: tb/tb_tim_base_core.sv
// Bench for tim_base_core: directed scenarios with constant expectations plus
// randomized traffic checked against a cycle-level behavioural model.
module tb_tim_base_core;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned PSC_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             en, ar, dir, ud;
  logic [PSC_W-1:0] div;
  logic [CNT_W-1:0] per, load;
  logic [CNT_W-1:0] cnt_out;
  logic             of_out, op_out, err_out, ld_out, tick_out, evt_out;

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  bit        m_on, m_halt, m_ud_prev;
  bit        m_of, m_op, m_err, m_ld, m_tick, m_evt;
  bit [31:0] m_cnt, m_psc;

  tim_base_core #(.CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
    .clk(clk), .rst(rst), .en_in(en), .ar_in(ar), .dir_in(dir), .ud_in(ud),
    .div_in(div), .per_in(per), .load_in(load), .cnt_out(cnt_out),
    .of_out(of_out), .op_out(op_out), .err_out(err_out), .ld_out(ld_out),
    .tick_out(tick_out), .evt_out(evt_out)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_on = 0; m_halt = 0; m_ud_prev = 0;
    {m_of, m_op, m_err, m_ld, m_tick, m_evt} = 6'b0;
    m_cnt = 32'd0; m_psc = 32'd0;
  endtask

  // One clock of the timer's rules, using the inputs present at the edge.
  task automatic model_update();
    bit req, ok, adv;
    if (rst) begin
      model_reset();
      return;
    end
    req = ud && !m_ud_prev;
    m_ud_prev = ud;
    ok = req && (load <= per);
    adv = 0; m_tick = 0; m_evt = 0;
    if (!m_on) begin
      if (en && per != '0) begin
        m_on = 1; m_halt = 0; m_psc = 32'd0;
        {m_of, m_op, m_err, m_ld} = 4'b0;
      end else if (en) begin
        m_err = 1;
      end
    end else if (!en) begin
      m_on = 0; m_halt = 0; m_psc = 32'd0;
    end else if (!m_halt) begin
      if (m_psc == div) begin
        adv = 1; m_psc = 32'd0;
      end else begin
        m_psc = m_psc + 32'd1;
      end
    end
    if (adv && !ok) begin
      m_tick = 1;
      if (dir ? (m_cnt == 32'd0) : (m_cnt >= per)) begin
        m_evt = 1; m_op = 1;
        if (ar) begin
          m_of = 1;
          m_cnt = dir ? per : 32'd0;
        end else begin
          m_halt = 1;
        end
      end else begin
        m_cnt = dir ? m_cnt - 32'd1 : m_cnt + 32'd1;
      end
    end
    if (ok) begin
      m_cnt = load; m_psc = 32'd0; m_ld = 1;
      if (m_on && en) m_halt = 0;
    end else if (req) begin
      m_err = 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1; en = 0; ar = 0; dir = 0; ud = 0;
    div = '0; per = '0; load = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; en = 0; ar = 0; dir = 0; ud = 0;
    div = '0; per = '0; load = '0;
    #3;
    total++;
    if (cnt_out !== 32'd0) begin
      bad++; $display("FAIL reset_cnt: got %0d expected 0", cnt_out);
    end
    total++;
    if ({of_out, op_out, err_out, ld_out, tick_out, evt_out} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b expected 000000",
               {of_out, op_out, err_out, ld_out, tick_out, evt_out});
    end
    do_reset();
  endtask

  task automatic test_wrap();
    int exp_cnt[5] = '{0, 1, 2, 3, 0};
    do_reset();
    div = '0; per = 32'd3; ar = 1; dir = 0; en = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (cnt_out !== 32'(exp_cnt[i])) begin
        bad++; $display("FAIL wrap_cnt[%0d]: got %0d expected %0d", i, cnt_out, exp_cnt[i]);
      end
    end
    total++;
    if ({evt_out, of_out, op_out} !== 3'b111) begin
      bad++; $display("FAIL wrap_evt_of_op: got %b expected 111", {evt_out, of_out, op_out});
    end
  endtask

  task automatic test_oneshot();
    do_reset();
    div = 32'd2; per = 32'd5; ar = 0; dir = 0; en = 1;
    for (int e = 1; e <= 25; e++) begin
      step();
      if (e >= 4 && e <= 16 && (e - 1) % 3 == 0) begin
        total++;
        if (cnt_out !== 32'((e - 1) / 3) || tick_out !== 1'b1) begin
          bad++;
          $display("FAIL oneshot_step e=%0d: got cnt=%0d tick=%b expected cnt=%0d tick=1",
                   e, cnt_out, tick_out, (e - 1) / 3);
        end
      end
      if (e == 19) begin
        total++;
        if (evt_out !== 1'b1 || op_out !== 1'b1 || cnt_out !== 32'd5) begin
          bad++;
          $display("FAIL oneshot_term: got evt=%b op=%b cnt=%0d expected 1 1 5",
                   evt_out, op_out, cnt_out);
        end
      end
    end
    total++;
    if (cnt_out !== 32'd5 || op_out !== 1'b1 || of_out !== 1'b0 || tick_out !== 1'b0) begin
      bad++;
      $display("FAIL oneshot_done: got cnt=%0d op=%b of=%b tick=%b expected 5 1 0 0",
               cnt_out, op_out, of_out, tick_out);
    end
  endtask

  task automatic test_load_down();
    int exp_cnt[5] = '{3, 2, 1, 0, 10};
    do_reset();
    dir = 1; per = 32'd10; ar = 1; div = '0; load = 32'd4; ud = 1; en = 1;
    step();
    total++;
    if (cnt_out !== 32'd4 || ld_out !== 1'b1) begin
      bad++; $display("FAIL load_accept: got cnt=%0d ld=%b expected 4 1", cnt_out, ld_out);
    end
    ud = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (cnt_out !== 32'(exp_cnt[i])) begin
        bad++; $display("FAIL down_cnt[%0d]: got %0d expected %0d", i, cnt_out, exp_cnt[i]);
      end
    end
    total++;
    if (of_out !== 1'b1 || evt_out !== 1'b1) begin
      bad++; $display("FAIL down_reload: got of=%b evt=%b expected 1 1", of_out, evt_out);
    end
  endtask

  task automatic test_load_reject();
    do_reset();
    per = 32'd10; div = '0; dir = 0; ar = 1; load = 32'd20; en = 1;
    repeat (3) step();
    ud = 1;
    step();
    total++;
    if (cnt_out !== 32'd3 || err_out !== 1'b1 || ld_out !== 1'b0) begin
      bad++;
      $display("FAIL load_reject: got cnt=%0d err=%b ld=%b expected 3 1 0",
               cnt_out, err_out, ld_out);
    end
    step();
    total++;
    if (cnt_out !== 32'd4) begin
      bad++; $display("FAIL reject_continue: got %0d expected 4", cnt_out);
    end
    ud = 0;
  endtask

  task automatic test_load_tick();
    do_reset();
    div = 32'd3; per = 32'd20; dir = 0; ar = 1; load = 32'd7; en = 1;
    for (int e = 1; e <= 13; e++) begin
      if (e == 9) ud = 1;
      if (e == 10) ud = 0;
      step();
      if (e == 5) begin
        total++;
        if (cnt_out !== 32'd1) begin
          bad++; $display("FAIL tick_first: got %0d expected 1", cnt_out);
        end
      end
      if (e == 9) begin
        total++;
        if (cnt_out !== 32'd7 || tick_out !== 1'b0 || evt_out !== 1'b0 || ld_out !== 1'b1) begin
          bad++;
          $display("FAIL load_vs_tick: got cnt=%0d tick=%b evt=%b ld=%b expected 7 0 0 1",
                   cnt_out, tick_out, evt_out, ld_out);
        end
      end
      if (e >= 10 && e <= 12) begin
        total++;
        if (cnt_out !== 32'd7) begin
          bad++; $display("FAIL load_hold e=%0d: got %0d expected 7", e, cnt_out);
        end
      end
      if (e == 13) begin
        total++;
        if (cnt_out !== 32'd8 || tick_out !== 1'b1) begin
          bad++;
          $display("FAIL load_next_tick: got cnt=%0d tick=%b expected 8 1", cnt_out, tick_out);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    div = '0; per = 32'd3; ar = 1; dir = 0; en = 1;
    repeat (6) step();
    #2;
    rst = 1;
    #1;
    model_reset();
    total++;
    if ({cnt_out, of_out, op_out, err_out, ld_out, tick_out, evt_out} !== 38'd0) begin
      bad++;
      $display("FAIL async_reset: got cnt=%0d flags=%b expected all 0", cnt_out,
               {of_out, op_out, err_out, ld_out, tick_out, evt_out});
    end
    @(posedge clk);
    #2;
    rst = 0; en = 0;
    repeat (2) step();
    total++;
    if (cnt_out !== 32'd0 || tick_out !== 1'b0) begin
      bad++; $display("FAIL idle_after_rst: got cnt=%0d tick=%b expected 0 0", cnt_out, tick_out);
    end
    en = 1;
    step();
    step();
    total++;
    if (cnt_out !== 32'd1) begin
      bad++; $display("FAIL restart_after_rst: got %0d expected 1", cnt_out);
    end
  endtask

  task automatic test_random();
    int r;
    logic [37:0] got, exp;
    do_reset();
    for (int seg = 0; seg < 8; seg++) begin
      en = 0; ud = 0;
      step();
      div = 32'($urandom_range(0, 3));
      per = 32'($urandom_range(1, 12));
      ar = 1'($urandom_range(0, 1));
      dir = 1'($urandom_range(0, 1));
      en = 1;
      for (int c = 0; c < 150; c++) begin
        r = int'($urandom_range(0, 99));
        if (r < 8) ud = ~ud;
        load = 32'($urandom_range(0, 15));
        if (r >= 8 && r < 10) ar = ~ar;
        if (r == 10) dir = ~dir;
        if (r == 11) per = 32'($urandom_range(0, 12));
        if (r == 12) en = 0;
        else if (r >= 13 && r < 20) en = 1;
        step();
        got = {cnt_out, of_out, op_out, err_out, ld_out, tick_out, evt_out};
        exp = {m_cnt, m_of, m_op, m_err, m_ld, m_tick, m_evt};
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL random seg=%0d cyc=%0d: got cnt=%0d flags=%b expected cnt=%0d flags=%b",
                   seg, c, got[37:6], got[5:0], exp[37:6], exp[5:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_oneshot();
    test_load_down();
    test_load_reject();
    test_load_tick();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
